instr_rom_sequencer: RTL

Parametrised, writable successor to the fixed 16-entry instruction ROM mux. It holds DEPTH instruction words and a program counter (PC), and streams instructions out through a valid/ready handshake. It supports run/stop control, jump requests, and wrap or stop-at-end modes. It sits between program-load logic (testbench or loader) and the datapath's instruction register. Illegal selections are reported through a sticky error flag, not a simulation message.

---
 rtl/instr_rom_sequencer_pkg.sv | 24 ++
 rtl/instr_rom_sequencer_mem.sv | 34 +++
 rtl/instr_rom_sequencer.sv | 131 +++++++++++++
 3 files changed

// File: rtl/instr_rom_sequencer_pkg.sv
// instr_rom_sequencer_pkg: shared types and constants.
// Sequencer state encoding and the legacy 16-word program image.
package instr_rom_sequencer_pkg;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_DONE = 2'd2
  } seq_state_e;

  localparam int PROG_LEN = 16;

  localparam logic [31:0] DEFAULT_PROG [PROG_LEN] = '{
    32'h2008_0002, 32'h2409_0004,
    32'h0109_5020, 32'h0109_5822,
    32'h0109_6024, 32'h0109_6825,
    32'h0109_702A, 32'hAC0A_0000,
    32'h8C0B_0000, 32'h1109_0002,
    32'h0000_0000, 32'h0800_0000,
    32'h3C12_FFFF, 32'h3413_F0F0,
    32'h3814_AAAA, 32'h3015_0003
  };

endpackage

// File: rtl/instr_rom_sequencer_mem.sv
// instr_mem_regfile: DEPTH x DATA_W program store.
// One synchronous write port, one combinational read port.
module instr_mem_regfile
  import instr_rom_sequencer_pkg::*;
#(
  parameter int DATA_W = 32,
  parameter int DEPTH  = 16,
  parameter int IDX_W  = $clog2(DEPTH)
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              we,
  input  logic [IDX_W-1:0]  waddr,
  input  logic [DATA_W-1:0] wdata,
  input  logic [IDX_W-1:0]  raddr,
  output logic [DATA_W-1:0] rdata
);

  logic [DATA_W-1:0] mem [DEPTH];

  // Array storage; reset wipes the whole program.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < DEPTH; i++) begin
        mem[i] <= '0;
      end
    end else if (we) begin
      mem[waddr] <= wdata;
    end
  end

  assign rdata = mem[raddr];

endmodule

// File: rtl/instr_rom_sequencer.sv
// instr_rom_sequencer: writable program store plus PC sequencer.
// Streams words out over valid/ready with run/stop/jump control.
module instr_rom_sequencer
  import instr_rom_sequencer_pkg::*;
#(
  parameter int DATA_W = 32,
  parameter int DEPTH  = 16,
  parameter int ADDR_W = $clog2(DEPTH),
  parameter int WRAP   = 0
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              wr_en,
  input  logic [ADDR_W-1:0] wr_addr,
  input  logic [DATA_W-1:0] wr_data,
  input  logic              start,
  input  logic              stop,
  input  logic              jump_en,
  input  logic [ADDR_W-1:0] jump_addr,
  output logic [DATA_W-1:0] instr_out,
  output logic              instr_valid,
  input  logic              instr_ready,
  output logic [ADDR_W-1:0] pc_out,
  output logic              busy,
  output logic              done,
  output logic              err
);

  localparam int IDX_W = $clog2(DEPTH);
  localparam logic [ADDR_W:0] DEPTH_X =
    (ADDR_W+1)'(DEPTH);
  localparam logic [ADDR_W-1:0] LAST =
    ADDR_W'(DEPTH - 1);

  seq_state_e state, state_d;
  logic [ADDR_W-1:0] pc, pc_d;
  logic err_d;
  logic fetch;
  logic wr_ok;
  logic wr_in, jump_in;
  logic [DATA_W-1:0] rd_data;

  assign wr_in   = {1'b0, wr_addr} < DEPTH_X;
  assign jump_in = {1'b0, jump_addr} < DEPTH_X;
  assign wr_ok   = wr_en && wr_in
                && (state != S_RUN);

  instr_mem_regfile #(
    .DATA_W (DATA_W),
    .DEPTH  (DEPTH),
    .IDX_W  (IDX_W)
  ) u_mem (
    .clk   (clk),
    .rst_n (rst_n),
    .we    (wr_ok),
    .waddr (wr_addr[IDX_W-1:0]),
    .wdata (wr_data),
    .raddr (pc[IDX_W-1:0]),
    .rdata (rd_data)
  );

  // Next state, next PC, error flag and fetch decision.
  always_comb begin
    state_d = state;
    pc_d    = pc;
    err_d   = err;
    fetch   = 1'b0;
    unique case (state)
      S_IDLE, S_DONE: begin
        if (start) begin
          state_d = S_RUN;
          pc_d    = '0;
          err_d   = 1'b0;
        end
      end
      S_RUN: begin
        if (stop) begin
          state_d = S_IDLE;
        end else if (!instr_valid
                     || instr_ready) begin
          fetch = 1'b1;
          if (jump_en && jump_in) begin
            pc_d = jump_addr;
          end else begin
            if (jump_en) err_d = 1'b1;
            if (pc == LAST) begin
              if (WRAP != 0) pc_d = '0;
              else state_d = S_DONE;
            end else begin
              pc_d = pc + 1'b1;
            end
          end
        end
      end
      default: state_d = S_IDLE;
    endcase
    if (wr_en && !wr_ok) err_d = 1'b1;
  end

  // Sequencer state, PC and sticky error.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= S_IDLE;
      pc    <= '0;
      err   <= 1'b0;
    end else begin
      state <= state_d;
      pc    <= pc_d;
      err   <= err_d;
    end
  end

  // Output word register with valid/ready hold.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      instr_out   <= '0;
      pc_out      <= '0;
      instr_valid <= 1'b0;
    end else if (fetch) begin
      instr_out   <= rd_data;
      pc_out      <= pc;
      instr_valid <= 1'b1;
    end else if (instr_valid && instr_ready) begin
      instr_valid <= 1'b0;
    end
  end

  assign busy = (state == S_RUN);
  assign done = (state == S_DONE);

endmodule
